counter_updown_mod: RTL
=======================

COUNTER_UPDOWN_MOD -- requirements
Module: counter_updown_mod

Interface
REQ-001: The block SHALL have parameter width, default 8, giving the counter and data bit width (legal range 2..32).
REQ-002: The block SHALL have parameter saturate, default 0: 0 = wrap at the range ends, 1 = hold at the range ends.
REQ-003: The block SHALL have port clk  input  1  system clock; all state updates on the rising edge.
REQ-004: The block SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005: The block SHALL have port enable  input  1  count enable.
REQ-006: The block SHALL have port load  input  1  synchronous parallel load.
REQ-007: The block SHALL have port data_in  input  width  load value.
REQ-008: The block SHALL have port dir  input  1  count direction: 1 = up, 0 = down.
REQ-009: The block SHALL have port limit  input  width  upper bound; the count range is 0..limit.
REQ-010: The block SHALL have port clr_flags  input  1  clears the sticky flags.
REQ-011: The block SHALL have port out  output  width  registered count value.
REQ-012: The block SHALL have port tc  output  1  registered terminal-count pulse.
REQ-013: The block SHALL have port ovf  output  1  sticky up-direction boundary flag.
REQ-014: The block SHALL have port unf  output  1  sticky down-direction boundary flag.

Function
REQ-015: Per-edge priority SHALL be: rst, then load, then enable, then hold.
REQ-016: On load, out SHALL become min(data_in, limit); tc SHALL be 0 in the following cycle and ovf/unf SHALL not change, regardless of enable.
REQ-017: With enable=1, dir=1 and out<limit, out SHALL increment by 1.
REQ-018: With enable=1, dir=1 and out>=limit (an up event), out SHALL become 0 when saturate=0 or limit when saturate=1; tc SHALL be 1 next cycle and ovf SHALL set.
REQ-019: With enable=1, dir=0 and out>0, out SHALL decrement by 1, including when out>limit after a runtime change of limit.
REQ-020: With enable=1, dir=0 and out==0 (a down event), out SHALL become limit when saturate=0 or stay 0 when saturate=1; tc SHALL be 1 next cycle and unf SHALL set.
REQ-021: tc SHALL be high for exactly the cycle after each boundary event; back-to-back events SHALL hold tc high continuously.
REQ-022: With enable=0 and load=0, out, ovf and unf SHALL hold and tc SHALL be 0.
REQ-023: With limit==0 and enable=1, out SHALL remain 0 and every cycle SHALL be a boundary event.
REQ-024: clr_flags SHALL clear ovf and unf on the next edge; a boundary event in the same cycle SHALL win, setting its flag.
REQ-025: dir and limit SHALL take effect on the same edge they are sampled, with no pipeline delay.
REQ-026: All arithmetic SHALL be modulo 2^width, with no internal carry visible on any output.

Reset
REQ-027: With rst=1 at a rising edge, out SHALL become 0 and tc, ovf and unf SHALL become 0, overriding load, enable and clr_flags.
REQ-028: Reset SHALL be honoured mid-count with no partial update, and counting SHALL resume from 0 on the first edge with rst=0.

Verification
REQ-029: width=4, saturate=0, limit=9, dir=1, enable high for 12 cycles from reset -> out 1..9,0,1,2; tc high only the cycle after 9->0; ovf=1.
REQ-030: limit=9, load=1, data_in=13 -> out=9; then load=1, enable=1, data_in=5 -> out=5, tc=0, flags unchanged.
REQ-031: saturate=1, out=2, dir=0, enable high for 4 cycles -> out 1,0,0,0; tc high for the last 2 cycles; unf=1.
REQ-032: ovf=1, clr_flags=1 together with an up event -> ovf stays 1; then clr_flags=1 with enable=0 -> ovf=0.
REQ-033: Counting at out=6, rst=1 together with load=1 and data_in=3 -> out=0 and tc/ovf/unf=0 next edge; release -> 1,2,...
REQ-034: width=8, limit=255, dir=1, start at 254 -> 255, then 0 with tc pulse; then dir=0 at 0 -> 255 with unf=1.

Source files
------------

// File: rtl/counter_updown_mod.sv
// Up/down counter with a runtime upper bound (range 0..limit), optional
// saturation at the range ends, a registered terminal-count pulse and sticky
// overflow/underflow flags.
module counter_updown_mod #(
  parameter int width    = 8,  // counter and data width, 2..32
  parameter int saturate = 0   // 0: wrap at range ends, 1: hold at range ends
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load,
  input  logic [width-1:0] data_in,
  input  logic             dir,
  input  logic [width-1:0] limit,
  input  logic             clr_flags,
  output logic [width-1:0] out,
  output logic             tc,
  output logic             ovf,
  output logic             unf
);

  localparam logic [width-1:0] ONE  = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] ZERO = '0;

  logic [width-1:0] r_count;
  logic             r_tc;
  logic             r_ovf;
  logic             r_unf;

  logic             w_up_evt;
  logic             w_dn_evt;
  logic [width-1:0] w_load_val;
  logic [width-1:0] w_count_next;
  logic             w_tc_next;
  logic             w_ovf_next;
  logic             w_unf_next;

  // Boundary events: an up step at or above the bound, or a down step at zero.
  // A count sitting above a freshly lowered limit still decrements normally.
  assign w_up_evt   = enable &  dir & (r_count >= limit);
  assign w_dn_evt   = enable & ~dir & (r_count == ZERO);
  assign w_load_val = (data_in > limit) ? limit : data_in;

  // Next-state selection in priority order: load, then enable, then hold.
  always_comb begin
    w_count_next = r_count;
    w_tc_next    = 1'b0;
    w_ovf_next   = r_ovf;
    w_unf_next   = r_unf;
    if (load) begin
      // Load leaves the sticky flags untouched, even if clr_flags is high.
      w_count_next = w_load_val;
    end else begin
      if (clr_flags) begin
        w_ovf_next = 1'b0;
        w_unf_next = 1'b0;
      end
      if (enable) begin
        if (dir) begin
          if (w_up_evt) begin
            w_count_next = (saturate != 0) ? limit : ZERO;
            w_tc_next    = 1'b1;
            w_ovf_next   = 1'b1;
          end else begin
            w_count_next = r_count + ONE;
          end
        end else begin
          if (w_dn_evt) begin
            w_count_next = (saturate != 0) ? ZERO : limit;
            w_tc_next    = 1'b1;
            w_unf_next   = 1'b1;
          end else begin
            w_count_next = r_count - ONE;
          end
        end
      end
    end
  end

  // State registers; reset overrides every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= ZERO;
      r_tc    <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_count <= w_count_next;
      r_tc    <= w_tc_next;
      r_ovf   <= w_ovf_next;
      r_unf   <= w_unf_next;
    end
  end

  assign out = r_count;
  assign tc  = r_tc;
  assign ovf = r_ovf;
  assign unf = r_unf;

endmodule
